// File: rtl/seq_pc_controller_pkg.sv
// seq_ctrl_pkg: shared states and constants for the multi-cycle PC sequencer
package seq_ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [31:0] HALT_INSTR = 32'h0;
  localparam logic [63:0] PC_STEP = 64'd4;
  function automatic logic is_mem_op(input logic [6:0] opc);
    return opc == OPC_LOAD || opc == OPC_STORE;
  endfunction
endpackage

// File: rtl/seq_pc_controller_if.sv
// seq_pc_controller_if: instruction/data memory handshake between sequencer and memories
interface seq_pc_controller_if;
  logic imem_req;
  logic imem_ready;
  logic [31:0] instr;
  logic dmem_req;
  logic dmem_ready;
  modport master(output imem_req, dmem_req, input imem_ready, instr, dmem_ready);
  modport slave(input imem_req, dmem_req, output imem_ready, instr, dmem_ready);
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: branch-or-sequential next PC and its alignment check
module pc_next_calc
  import seq_ctrl_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [63:0] imm,
  input  logic        taken,
  output logic [63:0] target,
  output logic        misaligned
);
  always_comb begin
    target = taken ? pc + (imm << 1) : pc + PC_STEP;
    misaligned = |target[1:0];
  end
endmodule

// File: rtl/seq_pc_controller.sv
// seq_pc_controller: five-step instruction sequencer owning the architectural PC
module seq_pc_controller
  import seq_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  seq_pc_controller_if.master        mem,
  input  logic                       branch,
  input  logic                       zero,
  input  logic signed [63:0]         imm,
  output logic [63:0]                pc,
  output logic [31:0]                instr_q,
  output logic                       id_en,
  output logic                       ex_en,
  output logic                       mem_en,
  output logic                       wb_en,
  output logic                       retire,
  output logic                       halted,
  output logic                       misalign,
  output logic [63:0]                retire_cnt
);
  state_t state;
  logic [63:0] target, target_w;
  logic tgt_mis, mis_w;
  pc_next_calc u_next (
    .pc(pc),
    .imm(imm),
    .taken(branch & zero),
    .target(target_w),
    .misaligned(mis_w)
  );
  // imem_req and retire are masked while reset is held so reset reads as all-idle
  always_comb begin
    mem.imem_req = state == FETCH && !reset;
    mem.dmem_req = state == MEMORY;
    id_en = state == DECODE;
    ex_en = state == EXECUTE;
    mem_en = state == MEMORY;
    wb_en = state == WRITEBACK;
    retire = state == WRITEBACK && !reset;
    halted = state == HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      instr_q <= '0;
      retire_cnt <= '0;
      misalign <= 1'b0;
      target <= '0;
      tgt_mis <= 1'b0;
    end else begin
      case (state)
        FETCH: if (mem.imem_ready) begin
          instr_q <= mem.instr;
          state <= mem.instr == HALT_INSTR ? HALT : DECODE;
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          target <= target_w;
          tgt_mis <= mis_w;
          state <= is_mem_op(instr_q[6:0]) ? MEMORY : WRITEBACK;
        end
        MEMORY: if (mem.dmem_ready) state <= WRITEBACK;
        WRITEBACK: begin
          retire_cnt <= retire_cnt + 64'd1;
          if (tgt_mis) begin
            misalign <= 1'b1;
            state <= HALT;
          end else begin
            pc <= target;
            state <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pc_controller.sv
// tb_seq_pc_controller: randomized transaction-level check of the PC sequencer
module tb_seq_pc_controller;
  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] I_ADD = 32'h00208133;
  localparam logic [31:0] I_BEQ = 32'h00208063;
  localparam logic [31:0] I_LW = 32'h0000a103;
  localparam logic [31:0] I_SW = 32'h0020a023;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic branch = 1'b0, zero = 1'b0;
  logic signed [63:0] imm = '0;
  logic [63:0] pc, retire_cnt;
  logic [31:0] instr_q;
  logic id_en, ex_en, mem_en, wb_en, retire, halted, misalign;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] pc_m, cnt_m;
  logic halt_m, mis_m;
  always #5 clk = ~clk;
  seq_pc_controller_if bus();
  seq_pc_controller #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .mem(bus), .branch(branch), .zero(zero), .imm(imm),
    .pc(pc), .instr_q(instr_q), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
    .wb_en(wb_en), .retire(retire), .halted(halted), .misalign(misalign),
    .retire_cnt(retire_cnt)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_retire", retire, 0);
    check("rst_enables", {id_en, ex_en, mem_en, wb_en, halted}, 0);
    check("rst_pc", pc, RPC);
    check("rst_cnt", retire_cnt, 0);
    check("rst_instr_q", instr_q, 0);
    check("rst_misalign", misalign, 0);
    reset = 1'b0;
    #1;
    check("first_fetch_req", bus.imem_req, 1);
    pc_m = RPC;
    cnt_m = '0;
    halt_m = 1'b0;
    mis_m = 1'b0;
  endtask
  task automatic halt_hold();
    logic ok = 1'b1;
    repeat (6) begin
      bus.imem_ready = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      bus.instr = $urandom;
      @(negedge clk);
      if (!halted || bus.imem_req || bus.dmem_req || retire || pc !== pc_m || retire_cnt !== cnt_m) ok = 1'b0;
    end
    check("halt_absorbing", ok, 1);
  endtask
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic br,
                           input logic z, input logic [63:0] im);
    logic [63:0] pc0 = pc_m;
    logic mem_op = ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011;
    int lat = ins == 32'h0 ? iw + 1 : iw + (mem_op ? 5 + dw : 4);
    logic [63:0] tgt = (br & z) ? pc_m + (im << 1) : pc_m + 64'd4;
    int fc = 0, dc = 0, cyc = 0, ret = 0;
    logic left = 1'b0, pc_ok = 1'b1, iq_ok = 1'b1, done = 1'b0;
    check("fetch_req", bus.imem_req, 1);
    while (!done && cyc < 100) begin
      bus.imem_ready = bus.imem_req ? fc == iw : 1'($urandom);
      bus.instr = (bus.imem_req && fc == iw) ? ins : $urandom;
      if (bus.imem_req) fc++;
      bus.dmem_ready = bus.dmem_req ? dc == dw : 1'($urandom);
      if (bus.dmem_req) dc++;
      {branch, zero} = ex_en ? {br, z} : 2'($urandom);
      imm = ex_en ? im : {$urandom, $urandom};
      @(negedge clk);
      cyc++;
      ret += int'(retire);
      if (!bus.imem_req) left = 1'b1;
      done = halted || (left && bus.imem_req);
      if (!done && pc !== pc0) pc_ok = 1'b0;
      if ((id_en | ex_en | mem_en | wb_en) && instr_q !== ins) iq_ok = 1'b0;
    end
    if (ins == 32'h0) halt_m = 1'b1;
    else begin
      cnt_m = cnt_m + 64'd1;
      if (tgt[1:0] != 2'b00) begin
        halt_m = 1'b1;
        mis_m = 1'b1;
      end else pc_m = tgt;
    end
    check("latency", cyc, lat);
    check("pc", pc, pc_m);
    check("retire_cnt", retire_cnt, cnt_m);
    check("retire_pulses", ret, ins != 32'h0);
    check("halted", halted, halt_m);
    check("misalign", misalign, mis_m);
    check("dmem_cycles", dc, (mem_op && ins != 32'h0) ? dw + 1 : 0);
    check("pc_const", pc_ok, 1);
    check("instr_q_stable", iq_ok, 1);
    check("instr_q", instr_q, ins);
  endtask
  task automatic reset_in_mem();
    int cyc = 0;
    logic ret = 1'b0;
    bus.imem_ready = 1'b1;
    bus.instr = I_LW;
    bus.dmem_ready = 1'b0;
    while (!bus.dmem_req && cyc < 10) begin
      @(negedge clk);
      bus.imem_ready = 1'b0;
      ret |= retire;
      cyc++;
    end
    check("reach_memory", bus.dmem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    ret |= retire;
    check("abandon_no_retire", ret, 0);
    check("abandon_pc", pc, RPC);
    check("abandon_cnt", retire_cnt, 0);
    do_reset();
  endtask
  initial begin
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.instr = '0;
    do_reset();
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0, 64'd0);
    repeat (3) run_instr(I_ADD, 0, 0, 1'b0, 1'b1, 64'd8);
    check("pc_0x1010", pc, 64'h1010);
    run_instr(I_BEQ, 0, 0, 1'b1, 1'b1, -64'sd4);
    check("beq_taken", pc, 64'h1008);
    run_instr(I_BEQ, 1, 0, 1'b1, 1'b0, -64'sd4);
    check("beq_not_taken", pc, 64'h100c);
    run_instr(I_LW, 0, 3, 1'b0, 1'b0, 64'd0);
    run_instr(I_SW, 2, 0, 1'b0, 1'b0, 64'd0);
    run_instr(I_BEQ, 0, 0, 1'b1, 1'b1, 64'd1);
    halt_hold();
    do_reset();
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0, 64'd0);
    run_instr(32'h0, 1, 0, 1'b0, 1'b0, 64'd0);
    halt_hold();
    do_reset();
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0, 64'd0);
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0, 64'd0);
    reset_in_mem();
    run_instr(I_BEQ, 0, 0, 1'b1, 1'b1, -64'sd2050);
    check("pc_top", pc, 64'hffff_ffff_ffff_fffc);
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0, 64'd0);
    check("pc_wrap", pc, 64'h0);
    for (int i = 0; i < 150; i++) begin
      int sel = $urandom_range(0, 19);
      int s = $urandom_range(0, 200) - 100;
      logic [31:0] ins;
      ins = sel == 0 ? 32'h0 : sel < 5 ? I_LW : sel < 8 ? I_SW : sel < 13 ? I_BEQ : sel < 16 ? I_ADD : $urandom | 32'h80;
      if ($urandom_range(0, 3) != 0) s = s & ~1;
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 64'(s));
      if (halt_m) begin
        halt_hold();
        do_reset();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
